// File: rtl/bram_burst_reader.sv
// bram_burst_reader
// Fetches a burst of consecutive words from a BRAM read port using a
// trig/done handshake (one handshake per word), buffers them in a 2-entry
// FIFO and presents them downstream on a valid/ready stream. A one-cycle
// done pulse marks the end of the burst once the last word has left the FIFO.
//
// Ports:
//   i_clk, i_rstn        clock (rising edge), asynchronous active-low reset
//   i_start              one-cycle command strobe, accepted only when idle
//   i_base_addr, i_len   burst start address and word count (0 = empty burst)
//   i_abort              cancel the running burst, no done pulse
//   o_busy, o_done       burst in progress / one-cycle completion pulse
//   o_bram_addr/trig     read request towards the BRAM responder
//   i_bram_data/done     read response from the BRAM responder
//   o_pix_data/valid     head-of-FIFO word / FIFO non-empty
//   i_pix_ready          downstream accepts the word when valid & ready
module bram_burst_reader #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 13
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [LEN_W-1:0]  i_len,
  input  logic              i_abort,
  output logic              o_busy,
  output logic              o_done,
  output logic [ADDR_W-1:0] o_bram_addr,
  output logic              o_bram_trig,
  input  logic [DATA_W-1:0] i_bram_data,
  input  logic              i_bram_done,
  output logic [DATA_W-1:0] o_pix_data,
  output logic              o_pix_valid,
  input  logic              i_pix_ready
);

  typedef enum logic [2:0] {IDLE, REQ, GAP, DRAIN, FIN} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    remaining_q, remaining_d;
  logic                trig_q, trig_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [DATA_W-1:0]   fifoMem_q [2];
  logic                wrPtr_q, wrPtr_d;
  logic                rdPtr_q, rdPtr_d;
  logic [1:0]          fifoCount_q, fifoCount_d;

  logic                push;
  logic                pop;
  logic                flush;

  // Next-state logic for the burst FSM and the FIFO bookkeeping.
  // Abort is evaluated last so it overrides whatever the FSM decided,
  // including discarding a read response that lands in the same cycle.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    trig_d      = trig_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    push        = 1'b0;
    flush       = 1'b0;
    pop         = (fifoCount_q != 2'd0) && i_pix_ready;

    case (state_q)
      IDLE: begin
        if (i_start) begin
          addr_d      = i_base_addr;
          remaining_d = i_len;
          busy_d      = 1'b1;
          if (i_len == '0) begin
            state_d = FIN;
          end else begin
            trig_d  = 1'b1;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (i_bram_done) begin
          push        = 1'b1;
          trig_d      = 1'b0;
          addr_d      = addr_q + 1'b1;
          remaining_d = remaining_q - 1'b1;
          state_d     = GAP;
        end
      end
      GAP: begin
        // A new read is only launched when its word is certain to fit,
        // counting a pop that happens in this same cycle.
        if (remaining_q == '0) begin
          state_d = DRAIN;
        end else if ((fifoCount_q < 2'd2) || pop) begin
          trig_d  = 1'b1;
          state_d = REQ;
        end
      end
      DRAIN: begin
        if (fifoCount_q == 2'd0) begin
          state_d = FIN;
        end
      end
      FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (i_abort && (state_q != IDLE)) begin
      state_d = IDLE;
      trig_d  = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      push    = 1'b0;
      flush   = 1'b1;
    end

    if (flush) begin
      wrPtr_d     = 1'b0;
      rdPtr_d     = 1'b0;
      fifoCount_d = 2'd0;
    end else begin
      wrPtr_d     = push ? ~wrPtr_q : wrPtr_q;
      rdPtr_d     = pop ? ~rdPtr_q : rdPtr_q;
      fifoCount_d = fifoCount_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // State and FIFO registers.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      remaining_q  <= '0;
      trig_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      wrPtr_q      <= 1'b0;
      rdPtr_q      <= 1'b0;
      fifoCount_q  <= 2'd0;
      fifoMem_q[0] <= '0;
      fifoMem_q[1] <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      trig_q      <= trig_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      fifoCount_q <= fifoCount_d;
      if (push) begin
        fifoMem_q[wrPtr_q] <= i_bram_data;
      end
    end
  end

  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_bram_addr = addr_q;
  assign o_bram_trig = trig_q;
  assign o_pix_data  = fifoMem_q[rdPtr_q];
  assign o_pix_valid = (fifoCount_q != 2'd0);

endmodule

// File: tb/tb_bram_burst_reader.sv
// tb_bram_burst_reader
// Directed bench for bram_burst_reader: a latency-1 BRAM responder returning
// the zero-extended address as data, a monitor that records accepted words,
// sampled read addresses, trig edges and done pulses, and directed tests.
module tb_bram_burst_reader;

  logic        clk;
  logic        rstn;
  logic        iStart;
  logic [12:0] iBase;
  logic [12:0] iLen;
  logic        iAbort;
  logic        oBusy;
  logic        oDone;
  logic [12:0] oAddr;
  logic        oTrig;
  logic [31:0] respData;
  logic        respDone;
  logic [31:0] oPixData;
  logic        oPixValid;
  logic        iPixReady;

  int checkCount = 0;
  int failCount  = 0;

  logic [31:0] gotQ[$];
  logic [31:0] addrQ[$];
  int          riseQ[$];
  int          highQ[$];
  int          cyc = 0;
  int          highRun = 0;
  int          doneCount = 0;
  logic        trigPrev = 1'b0;
  int          respCnt;

  bram_burst_reader #(.ADDR_W(13), .DATA_W(32), .LEN_W(13)) dut (
    .i_clk      (clk),
    .i_rstn     (rstn),
    .i_start    (iStart),
    .i_base_addr(iBase),
    .i_len      (iLen),
    .i_abort    (iAbort),
    .o_busy     (oBusy),
    .o_done     (oDone),
    .o_bram_addr(oAddr),
    .o_bram_trig(oTrig),
    .i_bram_data(respData),
    .i_bram_done(respDone),
    .o_pix_data (oPixData),
    .o_pix_valid(oPixValid),
    .i_pix_ready(iPixReady)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Latency-1 responder: done rises on the second edge that sees trig high,
  // and is dropped as soon as trig is seen with done already asserted.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      respCnt  <= 0;
      respDone <= 1'b0;
      respData <= 32'h0;
    end else if (oTrig && !respDone) begin
      if (respCnt == 1) begin
        respDone <= 1'b1;
        respData <= {19'b0, oAddr};
        respCnt  <= 0;
      end else begin
        respCnt <= respCnt + 1;
      end
    end else begin
      respDone <= 1'b0;
      respCnt  <= 0;
    end
  end

  // Monitor: records handshakes and trig timing at every rising edge.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (oPixValid && iPixReady) gotQ.push_back(oPixData);
    if (oTrig && respDone) addrQ.push_back({19'b0, oAddr});
    if (oTrig && !trigPrev) riseQ.push_back(cyc);
    if (oTrig) begin
      highRun = highRun + 1;
    end else if (trigPrev) begin
      highQ.push_back(highRun);
      highRun = 0;
    end
    if (oDone) doneCount = doneCount + 1;
    trigPrev = oTrig;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Clears the monitor records, then pulses start for one cycle.
  task automatic applyStimulus(input logic [12:0] base, input logic [12:0] len);
    @(negedge clk);
    gotQ.delete();
    addrQ.delete();
    riseQ.delete();
    highQ.delete();
    highRun   = 0;
    doneCount = 0;
    iStart = 1'b1;
    iBase  = base;
    iLen   = len;
    @(negedge clk);
    iStart = 1'b0;
  endtask

  task automatic waitDone(input int maxCycles);
    int n = 0;
    while (doneCount == 0 && n < maxCycles) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
  endtask

  function automatic logic [31:0] wordAt(input int i);
    if (i < gotQ.size()) return gotQ[i];
    return 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] addrAt(input int i);
    if (i < addrQ.size()) return addrQ[i];
    return 32'hDEAD_BEEF;
  endfunction

  initial begin
    int n;
    rstn = 1'b0; iStart = 1'b0; iBase = '0; iLen = '0;
    iAbort = 1'b0; iPixReady = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("rstBusy", oBusy, 0);
    checkOutput("rstDone", oDone, 0);
    checkOutput("rstTrig", oTrig, 0);
    checkOutput("rstValid", oPixValid, 0);
    checkOutput("rstAddr", oAddr, 0);
    rstn = 1'b1;
    @(negedge clk);

    // Basic burst
    applyStimulus(13'h010, 13'd4);
    checkOutput("basicBusyAfterStart", oBusy, 1);
    checkOutput("basicTrigAfterStart", oTrig, 1);
    waitDone(100);
    checkOutput("basicCount", gotQ.size(), 4);
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("basicWord%0d", i), wordAt(i), 32'h10 + i);
    checkOutput("basicRises", riseQ.size(), 4);
    for (int i = 1; i < riseQ.size(); i++)
      checkOutput($sformatf("basicPeriod%0d", i), riseQ[i] - riseQ[i-1], 4);
    checkOutput("basicHighRuns", highQ.size(), 4);
    for (int i = 0; i < highQ.size(); i++)
      checkOutput($sformatf("basicHigh%0d", i), highQ[i], 3);
    checkOutput("basicDonePulses", doneCount, 1);
    checkOutput("basicBusyEnd", oBusy, 0);

    // Backpressure
    iPixReady = 1'b0;
    applyStimulus(13'h000, 13'd6);
    repeat (20) @(negedge clk);
    checkOutput("bpReadsStalled", addrQ.size(), 2);
    checkOutput("bpTrigStalled", oTrig, 0);
    checkOutput("bpValidStalled", oPixValid, 1);
    iPixReady = 1'b1;
    waitDone(200);
    checkOutput("bpCount", gotQ.size(), 6);
    for (int i = 0; i < 6; i++)
      checkOutput($sformatf("bpWord%0d", i), wordAt(i), i);
    checkOutput("bpDonePulses", doneCount, 1);

    // Address wrap
    applyStimulus(13'h1FFE, 13'd4);
    waitDone(100);
    checkOutput("wrapAddr0", addrAt(0), 32'h1FFE);
    checkOutput("wrapAddr1", addrAt(1), 32'h1FFF);
    checkOutput("wrapAddr2", addrAt(2), 32'h0000);
    checkOutput("wrapAddr3", addrAt(3), 32'h0001);
    checkOutput("wrapCount", gotQ.size(), 4);
    checkOutput("wrapWord2", wordAt(2), 32'h0000);
    checkOutput("wrapWord3", wordAt(3), 32'h0001);

    // Zero length: done two cycles after the start cycle
    applyStimulus(13'h055, 13'd0);
    checkOutput("zeroDoneEarly", oDone, 0);
    @(negedge clk);
    checkOutput("zeroDone", oDone, 1);
    checkOutput("zeroBusyAtDone", oBusy, 0);
    @(negedge clk);
    checkOutput("zeroDoneOnce", oDone, 0);
    checkOutput("zeroNoTrig", riseQ.size(), 0);

    // Start while busy is ignored
    applyStimulus(13'h020, 13'd3);
    repeat (4) @(negedge clk);
    iStart = 1'b1; iBase = 13'h100; iLen = 13'd7;
    @(negedge clk);
    iStart = 1'b0;
    waitDone(100);
    checkOutput("sbCount", gotQ.size(), 3);
    for (int i = 0; i < 3; i++)
      checkOutput($sformatf("sbWord%0d", i), wordAt(i), 32'h20 + i);
    checkOutput("sbDonePulses", doneCount, 1);

    // Abort while the second read is pending and word 0 sits in the FIFO
    iPixReady = 1'b0;
    applyStimulus(13'h000, 13'd5);
    n = 0;
    while (!(addrQ.size() == 1 && oTrig) && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("abortReachReq", (addrQ.size() == 1) && oTrig, 1);
    checkOutput("abortValidBefore", oPixValid, 1);
    iAbort = 1'b1;
    @(negedge clk);
    iAbort = 1'b0;
    checkOutput("abortTrig", oTrig, 0);
    checkOutput("abortValid", oPixValid, 0);
    checkOutput("abortBusy", oBusy, 0);
    iPixReady = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("abortNoDone", doneCount, 0);
    checkOutput("abortNoMoreReads", addrQ.size(), 1);
    applyStimulus(13'h040, 13'd2);
    waitDone(100);
    checkOutput("postAbortCount", gotQ.size(), 2);
    checkOutput("postAbortWord0", wordAt(0), 32'h40);
    checkOutput("postAbortWord1", wordAt(1), 32'h41);

    // Reset during REQ with one word held in the FIFO
    iPixReady = 1'b0;
    applyStimulus(13'h050, 13'd3);
    n = 0;
    while (!(addrQ.size() == 1 && oTrig) && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("rstMidReachReq", oPixValid && oTrig, 1);
    #2 rstn = 1'b0;
    #1;
    checkOutput("rstMidBusy", oBusy, 0);
    checkOutput("rstMidTrig", oTrig, 0);
    checkOutput("rstMidValid", oPixValid, 0);
    checkOutput("rstMidAddr", oAddr, 0);
    checkOutput("rstMidData", oPixData, 0);
    checkOutput("rstMidDone", oDone, 0);
    @(negedge clk);
    rstn = 1'b1;
    iPixReady = 1'b1;
    applyStimulus(13'h060, 13'd1);
    waitDone(100);
    checkOutput("postRstCount", gotQ.size(), 1);
    checkOutput("postRstWord", wordAt(0), 32'h60);
    checkOutput("postRstDone", doneCount, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
